tcam_hit_encoder: RTL and testbench
===================================

TCAM_HIT_ENCODER -- requirements
Module: tcam_hit_encoder

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 16, number of TCAM entries (width of the hit vector).
REQ-002 SHALL have parameter IDX_W, default 4, index width; SHALL satisfy 2**IDX_W == N_ENTRIES.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 hits_valid  in  1  single-cycle strobe qualifying hits.
REQ-006 hits  in  N_ENTRIES  match vector from the TCAM lookup stage; bit i set means entry i matched.
REQ-007 idx_valid  out  1  idx holds a valid matched entry index.
REQ-008 idx  out  IDX_W  matched entry index.
REQ-009 idx_ready  in  1  consumer accepts idx when idx_valid and idx_ready are both 1.
REQ-010 last  out  1  current idx is the final index of this lookup.
REQ-011 miss  out  1  one-cycle pulse: the captured vector was all zero.
REQ-012 drop  out  1  one-cycle pulse: hits_valid arrived while busy and was discarded.
REQ-013 busy  out  1  encoder is emitting indices and cannot accept a new vector.

Function
REQ-014 SHALL implement two states, IDLE and EMIT; busy SHALL be 1 exactly when state is EMIT.
REQ-015 In IDLE with hits_valid=1 and hits!=0: SHALL capture hits into a pending register and enter EMIT; idx_valid SHALL be 1 on the next cycle (latency 1).
REQ-016 In IDLE with hits_valid=1 and hits==0: SHALL stay in IDLE and pulse miss for exactly one cycle on the next cycle.
REQ-017 In EMIT: idx SHALL equal the lowest-numbered set bit of pending; idx_valid SHALL be 1.
REQ-018 idx, last SHALL stay stable while idx_valid=1 and idx_ready=0.
REQ-019 On handshake: SHALL clear the emitted bit in pending; next cycle SHALL present the next-lowest set bit.
REQ-020 last SHALL be 1 when pending holds exactly one set bit.
REQ-021 On handshake with last=1: SHALL return to IDLE; idx_valid SHALL be 0 on the next cycle.
REQ-022 hits_valid=1 in EMIT (including the last-handshake cycle): vector SHALL be discarded, pending unchanged, drop pulsed for one cycle on the next cycle.
REQ-023 Back-to-back handshakes SHALL sustain one index per cycle; a vector of k set bits SHALL complete in k handshake cycles.
REQ-024 In IDLE, idx_valid, last SHALL be 0; idx SHALL be 0.

Reset
REQ-025 reset=1 at a rising edge SHALL force state IDLE, clear pending, drive idx_valid, idx, last, miss, drop, busy to 0; in-flight indices SHALL be discarded.
REQ-026 reset SHALL take priority over hits_valid and idx_ready in the same cycle.

Configuration
REQ-027 Macro TCAM_HIT_COUNT_EN: when defined, SHALL add output hit_count (IDX_W+1 bits) holding the popcount of the most recently captured vector, updated the cycle after capture (0 on miss), held until the next capture, reset to 0.
REQ-028 Without TCAM_HIT_COUNT_EN: hit_count port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 Reset, then hits_valid with hits=16'h8421, idx_ready=1 -> idx 0,5,10,15 on four consecutive cycles, last=1 only with idx=15, then IDLE.
REQ-030 hits=16'h0000 in IDLE -> miss=1 for one cycle, idx_valid stays 0, busy stays 0.
REQ-031 hits=16'h0006, idx_ready=0 for 3 cycles then 1 -> idx=1 held stable 4 cycles, then idx=2 with last=1.
REQ-032 hits=16'h00F0 captured, second hits_valid with 16'hFFFF during EMIT -> drop=1 one cycle; output is 4,5,6,7 only.
REQ-033 hits=16'hFFFF, reset asserted after 3 handshakes -> next cycle idx_valid=0, busy=0; new vector 16'h0001 then yields idx=0 with last=1.
REQ-034 With TCAM_HIT_COUNT_EN: hits=16'hFFFF -> hit_count=16; then hits=16'h0000 -> hit_count=0.

Source files
------------

// File: rtl/tcam_hit_encoder.sv
// Serializes a TCAM match vector into a stream of matched entry indices, lowest first.
// Optional macro TCAM_HIT_COUNT_EN adds hit_count_o, the popcount of the last captured vector.
module tcam_hit_encoder #(
   parameter int N_ENTRIES = 16,
   parameter int IDX_W     = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 hits_valid_i,
   input  logic [N_ENTRIES-1:0] hits_i,
   output logic                 idx_valid_o,
   output logic [IDX_W-1:0]     idx_o,
   input  logic                 idx_ready_i,
   output logic                 last_o,
   output logic                 miss_o,
   output logic                 drop_o,
   output logic                 busy_o
`ifdef TCAM_HIT_COUNT_EN
   ,
   output logic [IDX_W:0]       hit_count_o
`endif
);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   localparam logic [N_ENTRIES-1:0] ONE = N_ENTRIES'(1);

   state_t               state_q, state_d;
   logic [N_ENTRIES-1:0] pending_q, pending_d;
   logic                 miss_q, miss_d;
   logic                 drop_q, drop_d;

   logic [IDX_W-1:0]     low_idx;
   logic [N_ENTRIES-1:0] low_onehot;
   logic                 single_bit;
   logic                 handshake;

   // Scanning from the top lets the lowest set bit win.
   function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_ENTRIES-1:0] v);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = N_ENTRIES - 1; i >= 0; i--) begin
         if (v[i]) r = IDX_W'(i);
      end
      return r;
   endfunction

   function automatic logic [IDX_W:0] popcount(input logic [N_ENTRIES-1:0] v);
      logic [IDX_W:0] c;
      c = '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
         c = c + (IDX_W+1)'(v[i]);
      end
      return c;
   endfunction

   assign low_idx    = lowest_idx(pending_q);
   assign low_onehot = pending_q & (~pending_q + ONE);
   // Exactly one bit set: clearing the lowest bit leaves nothing behind.
   assign single_bit = (pending_q != '0) && ((pending_q & (pending_q - ONE)) == '0);
   assign handshake  = (state_q == EMIT) && idx_ready_i;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         pending_q <= '0;
         miss_q    <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         miss_q    <= miss_d;
         drop_q    <= drop_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      miss_d      = 1'b0;
      drop_d      = 1'b0;
      idx_valid_o = 1'b0;
      idx_o       = '0;
      last_o      = 1'b0;
      busy_o      = 1'b0;

      case (state_q)
         IDLE: begin
            if (hits_valid_i) begin
               if (hits_i != '0) begin
                  pending_d = hits_i;
                  state_d   = EMIT;
               end else begin
                  miss_d = 1'b1;
               end
            end
         end
         EMIT: begin
            idx_valid_o = 1'b1;
            idx_o       = low_idx;
            last_o      = single_bit;
            busy_o      = 1'b1;
            if (hits_valid_i) drop_d = 1'b1;
            if (handshake) begin
               pending_d = pending_q & ~low_onehot;
               if (single_bit) state_d = IDLE;
            end
         end
         default: begin
            state_d   = IDLE;
            pending_d = '0;
         end
      endcase
   end

   assign miss_o = miss_q;
   assign drop_o = drop_q;

`ifdef TCAM_HIT_COUNT_EN
   logic [IDX_W:0] hit_count_q, hit_count_d;

   // Only vectors accepted in IDLE count; dropped vectors leave the value alone.
   always_comb begin
      hit_count_d = hit_count_q;
      if (state_q == IDLE && hits_valid_i) hit_count_d = popcount(hits_i);
   end

   always_ff @(posedge clk) begin
      if (reset) hit_count_q <= '0;
      else       hit_count_q <= hit_count_d;
   end

   assign hit_count_o = hit_count_q;
`endif

endmodule

// File: tb/tb_tcam_hit_encoder.sv
// Directed self-checking bench for tcam_hit_encoder (16 entries, 4-bit index).
module tb_tcam_hit_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        hits_valid;
   logic [15:0] hits;
   logic        idx_valid;
   logic [3:0]  idx;
   logic        idx_ready;
   logic        last;
   logic        miss;
   logic        drop;
   logic        busy;
`ifdef TCAM_HIT_COUNT_EN
   logic [4:0]  hit_count;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   tcam_hit_encoder #(.N_ENTRIES(16), .IDX_W(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .hits_valid_i (hits_valid),
      .hits_i       (hits),
      .idx_valid_o  (idx_valid),
      .idx_o        (idx),
      .idx_ready_i  (idx_ready),
      .last_o       (last),
      .miss_o       (miss),
      .drop_o       (drop),
      .busy_o       (busy)
`ifdef TCAM_HIT_COUNT_EN
      ,
      .hit_count_o  (hit_count)
`endif
   );

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; hits_valid = 1'b0; hits = 16'h0; idx_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      checks++;
      if ({idx_valid, idx, last, miss, drop, busy} !== 9'b0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%0b idx=%0d last=%0b miss=%0b drop=%0b busy=%0b, want all 0",
                  idx_valid, idx, last, miss, drop, busy);
      end
   endtask

   task automatic test_basic_8421();
      int exp_idx [4] = '{0, 5, 10, 15};
      idx_ready = 1'b1; hits_valid = 1'b1; hits = 16'h8421;
      tick();
      hits_valid = 1'b0; hits = 16'h0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (idx_valid !== 1'b1 || idx !== 4'(exp_idx[k]) || last !== (k == 3) || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_step%0d: got valid=%0b idx=%0d last=%0b busy=%0b, want valid=1 idx=%0d last=%0b busy=1",
                     k, idx_valid, idx, last, busy, exp_idx[k], (k == 3));
         end
         tick();
      end
      checks++;
      if (idx_valid !== 1'b0 || busy !== 1'b0 || idx !== 4'd0 || last !== 1'b0) begin
         errors++;
         $display("FAIL basic_idle: got valid=%0b busy=%0b idx=%0d last=%0b, want 0 0 0 0",
                  idx_valid, busy, idx, last);
      end
   endtask

   task automatic test_miss();
      hits_valid = 1'b1; hits = 16'h0000;
      tick();
      hits_valid = 1'b0;
      checks++;
      if (miss !== 1'b1 || idx_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL miss_pulse: got miss=%0b valid=%0b busy=%0b, want 1 0 0", miss, idx_valid, busy);
      end
      tick();
      checks++;
      if (miss !== 1'b0 || idx_valid !== 1'b0) begin
         errors++;
         $display("FAIL miss_one_cycle: got miss=%0b valid=%0b, want 0 0", miss, idx_valid);
      end
   endtask

   task automatic test_backpressure();
      idx_ready = 1'b0; hits_valid = 1'b1; hits = 16'h0006;
      tick();
      hits_valid = 1'b0; hits = 16'h0;
      for (int c = 0; c < 4; c++) begin
         if (c == 3) idx_ready = 1'b1;
         checks++;
         if (idx_valid !== 1'b1 || idx !== 4'd1 || last !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: got valid=%0b idx=%0d last=%0b, want 1 1 0", c, idx_valid, idx, last);
         end
         tick();
      end
      checks++;
      if (idx_valid !== 1'b1 || idx !== 4'd2 || last !== 1'b1) begin
         errors++;
         $display("FAIL bp_second: got valid=%0b idx=%0d last=%0b, want 1 2 1", idx_valid, idx, last);
      end
      tick();
      checks++;
      if (idx_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_done: got valid=%0b busy=%0b, want 0 0", idx_valid, busy);
      end
   endtask

   task automatic test_drop();
      idx_ready = 1'b1; hits_valid = 1'b1; hits = 16'h00F0;
      tick();
      hits = 16'hFFFF;
      checks++;
      if (idx !== 4'd4 || drop !== 1'b0) begin
         errors++;
         $display("FAIL drop_first: got idx=%0d drop=%0b, want 4 0", idx, drop);
      end
      tick();
      hits_valid = 1'b0; hits = 16'h0;
      checks++;
      if (drop !== 1'b1 || idx !== 4'd5 || idx_valid !== 1'b1) begin
         errors++;
         $display("FAIL drop_pulse: got drop=%0b idx=%0d valid=%0b, want 1 5 1", drop, idx, idx_valid);
      end
      tick();
      checks++;
      if (drop !== 1'b0 || idx !== 4'd6 || last !== 1'b0) begin
         errors++;
         $display("FAIL drop_cont: got drop=%0b idx=%0d last=%0b, want 0 6 0", drop, idx, last);
      end
      tick();
      hits_valid = 1'b1; hits = 16'hFFFF;
      checks++;
      if (idx !== 4'd7 || last !== 1'b1) begin
         errors++;
         $display("FAIL drop_last: got idx=%0d last=%0b, want 7 1", idx, last);
      end
      tick();
      hits_valid = 1'b0; hits = 16'h0;
      checks++;
      if (drop !== 1'b1 || idx_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL drop_on_last: got drop=%0b valid=%0b busy=%0b, want 1 0 0", drop, idx_valid, busy);
      end
      tick();
      checks++;
      if (drop !== 1'b0 || idx_valid !== 1'b0) begin
         errors++;
         $display("FAIL drop_discarded: got drop=%0b valid=%0b, want 0 0", drop, idx_valid);
      end
   endtask

   task automatic test_reset_midflight();
      idx_ready = 1'b1; hits_valid = 1'b1; hits = 16'hFFFF;
      tick();
      hits_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (idx !== 4'(k) || idx_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre%0d: got idx=%0d valid=%0b, want %0d 1", k, idx, idx_valid, k);
         end
         tick();
      end
      reset = 1'b1; hits_valid = 1'b1; hits = 16'h0000;
      tick();
      reset = 1'b0; hits_valid = 1'b0;
      checks++;
      if (idx_valid !== 1'b0 || busy !== 1'b0 || miss !== 1'b0 || drop !== 1'b0 || idx !== 4'd0) begin
         errors++;
         $display("FAIL rst_flush: got valid=%0b busy=%0b miss=%0b drop=%0b idx=%0d, want all 0",
                  idx_valid, busy, miss, drop, idx);
      end
      hits_valid = 1'b1; hits = 16'h0001;
      tick();
      hits_valid = 1'b0; hits = 16'h0;
      checks++;
      if (idx_valid !== 1'b1 || idx !== 4'd0 || last !== 1'b1) begin
         errors++;
         $display("FAIL rst_new: got valid=%0b idx=%0d last=%0b, want 1 0 1", idx_valid, idx, last);
      end
      tick();
      checks++;
      if (idx_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_new_done: got valid=%0b busy=%0b, want 0 0", idx_valid, busy);
      end
   endtask

`ifdef TCAM_HIT_COUNT_EN
   task automatic test_hit_count();
      idx_ready = 1'b1; hits_valid = 1'b1; hits = 16'hFFFF;
      tick();
      hits_valid = 1'b0; hits = 16'h0;
      checks++;
      if (hit_count !== 5'd16) begin
         errors++;
         $display("FAIL hit_count_full: got %0d, want 16", hit_count);
      end
      for (int k = 0; k < 16; k++) tick();
      checks++;
      if (idx_valid !== 1'b0 || hit_count !== 5'd16) begin
         errors++;
         $display("FAIL hit_count_hold: got valid=%0b count=%0d, want 0 16", idx_valid, hit_count);
      end
      hits_valid = 1'b1; hits = 16'h0000;
      tick();
      hits_valid = 1'b0;
      checks++;
      if (hit_count !== 5'd0 || miss !== 1'b1) begin
         errors++;
         $display("FAIL hit_count_miss: got count=%0d miss=%0b, want 0 1", hit_count, miss);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic_8421();
      test_miss();
      test_backpressure();
      test_drop();
      test_reset_midflight();
`ifdef TCAM_HIT_COUNT_EN
      test_hit_count();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
